dpa_prec_ctrl: RTL
==================

// Module: dpa_prec_ctrl
// PURPOSE
//   Upstream precision controller for the power-saving register bank (p_dff).
//   Accepts a sample stream and picks the narrowest safe precision per sample.
//   Drives d/en/sel of the downstream p_dff so only bits [sel:0] toggle.
//   Leading-one detect plus guard bits; hysteresis delays precision shrink.
// PARAMETERS
//   WORD   24  sample / p_dff data width
//   NSEL   5   sel width; must satisfy 2**NSEL > WORD-1
//   GUARD  1   extra bits kept above the leading one
//   HOLD   4   accepted samples in a shrink window (>=1)
// PORTS
//   clk         in   1     rising-edge clock
//   reset       in   1     asynchronous, active-high reset
//   in_valid    in   1     sample valid; no backpressure, every valid is taken
//   in_data     in   WORD  unsigned sample
//   force_full  in   1     level; hold full precision (sel=WORD-1)
//   dff_en      out  1     p_dff en, registered
//   dff_sel     out  NSEL  p_dff sel, registered; bits [dff_sel:0] are written
//   dff_d       out  WORD  p_dff d, registered copy of in_data
//   cur_sel     out  NSEL  current committed precision (status)
// BEHAVIOUR
//   Reset (async): dff_en=0, dff_d=0, dff_sel=WORD-1, cur_sel=WORD-1,
//     cnt=0, winmax=0, state=TRACK. Reset mid-window drops the window.
//   Latency: sample valid at edge N appears on dff_d/dff_en/dff_sel after N+1.
//     Idle cycles (in_valid=0) give dff_en=0; dff_d/dff_sel hold; no state change.
//   Per accepted sample: m = index of highest set bit (m=0 for zero data);
//     need = min(m+GUARD, WORD-1). Compute at NSEL+1 bits, no wrap.
//   States: TRACK, FULL. TRACK->FULL when force_full=1; FULL->TRACK when 0.
//   FULL: each valid -> dff_sel=WORD-1; cur_sel<=WORD-1; cnt<=0; winmax<=0.
//     force_full applies in the same cycle it is sampled, including to a
//     concurrent sample.
//   TRACK, need > cur_sel (raise): dff_sel=need; cur_sel<=need; cnt<=0, winmax<=0.
//   TRACK, need <= cur_sel: dff_sel=cur_sel; winmax<=max(winmax,need); cnt++.
//     When this is the HOLD-th sample of the window: cur_sel<=max(winmax,need);
//     cnt<=0, winmax<=0. A shrink applies from the next sample only.
//   Invariant: p_dff bits above any shrunk sel were last written as 0,
//     because every window sample fit in max(winmax) bits.
//   dff_sel >= need of the sample it carries, always.
//   cnt width clog2(HOLD+1); must never wrap.
//   Leaving FULL: cur_sel=WORD-1 and a fresh window starts.
// TESTING  (WORD=24, NSEL=5, GUARD=1, HOLD=4)
//   Reset, then 4 valids of 0x000010 -> dff_sel=23 on all 4, cur_sel=5 after 4th;
//     5th 0x000010 -> dff_sel=5.
//   From cur_sel=5, valid 0x008000 -> next cycle dff_sel=16, cur_sel=16, window cleared.
//   Valid 0x800000 -> need saturates, dff_sel=23. Valid 0 -> need=1.
//   force_full=1 with valids of 0x1 -> dff_sel=23 every sample.
//   Release force_full, 4 valids of 0x1 -> cur_sel=1 after the 4th.
//   Gaps: valid,idle,idle,valid... -> dff_en=0 on idle cycles; only valids count.
//     Shrink occurs after exactly 4 valids.
//   Assert reset after 2 of 4 window samples -> outputs at reset values at once.
//     After release, 4 fresh samples are needed to shrink.

Source files
------------

// File: rtl/dpa_prec_ctrl_if.sv
// Sample-in / p_dff-drive bundle for the precision controller.
// The master side produces samples; the slave side is the controller itself.
interface dpa_prec_ctrl_if #(
   parameter int WORD = 24,
   parameter int NSEL = 5
);
   logic            in_valid;
   logic [WORD-1:0] in_data;
   logic            force_full;
   logic            dff_en;
   logic [NSEL-1:0] dff_sel;
   logic [WORD-1:0] dff_d;
   logic [NSEL-1:0] cur_sel;

   modport master (
      output in_valid,
      output in_data,
      output force_full,
      input  dff_en,
      input  dff_sel,
      input  dff_d,
      input  cur_sel
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  force_full,
      output dff_en,
      output dff_sel,
      output dff_d,
      output cur_sel
   );
endinterface

// File: rtl/dpa_prec_ctrl.sv
// Picks the narrowest safe p_dff precision per sample: leading-one plus guard
// bits, immediate widening, and shrinking only after a full window of samples.
module dpa_prec_ctrl #(
   parameter int WORD  = 24,
   parameter int NSEL  = 5,
   parameter int GUARD = 1,
   parameter int HOLD  = 4
) (
   input  logic          clk,
   input  logic          reset,
   dpa_prec_ctrl_if.slave bus
);

   localparam int CW = (HOLD < 1) ? 1 : $clog2(HOLD + 1);
   localparam logic [NSEL:0]   TOP_WIDE = (NSEL+1)'(WORD - 1);
   localparam logic [NSEL-1:0] TOP_SEL  = NSEL'(WORD - 1);
   localparam logic [NSEL:0]   GUARD_W  = (NSEL+1)'(GUARD);
   localparam logic [CW-1:0]   LAST_CNT = CW'(HOLD - 1);

   typedef enum logic {
      TRACK = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [NSEL-1:0] cur_q, cur_d;
   logic [NSEL-1:0] winmax_q, winmax_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic            en_q;
   logic [NSEL-1:0] sel_q, sel_d;
   logic [WORD-1:0] d_q;

   logic [NSEL:0]   lead;
   logic [NSEL:0]   need_raw;
   logic [NSEL-1:0] need;
   logic [NSEL-1:0] win_upd;

   // Base values after leaving FULL: full precision and an empty window.
   logic            leaving;
   logic [NSEL-1:0] cur_eff;
   logic [NSEL-1:0] winmax_eff;
   logic [CW-1:0]   cnt_eff;

   always_comb begin
      lead = '0;
      for (int i = 0; i < WORD; i++) begin
         if (bus.in_data[i]) lead = (NSEL+1)'(i);
      end
      need_raw = lead + GUARD_W;
      if (need_raw > TOP_WIDE) need = TOP_SEL;
      else                     need = need_raw[NSEL-1:0];
   end

   always_comb begin
      leaving    = (state_q == FULL) && !bus.force_full;
      cur_eff    = leaving ? TOP_SEL : cur_q;
      winmax_eff = leaving ? '0      : winmax_q;
      cnt_eff    = leaving ? '0      : cnt_q;
      win_upd    = (need > winmax_eff) ? need : winmax_eff;
   end

   // NOTE: every output of this block gets a default first so that no path
   // leaves a variable unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d  = bus.force_full ? FULL : TRACK;
      cur_d    = cur_eff;
      winmax_d = winmax_eff;
      cnt_d    = cnt_eff;
      sel_d    = sel_q;

      if (bus.in_valid) begin
         if (bus.force_full) begin
            sel_d    = TOP_SEL;
            cur_d    = TOP_SEL;
            winmax_d = '0;
            cnt_d    = '0;
         end else if (need > cur_eff) begin
            sel_d    = need;
            cur_d    = need;
            winmax_d = '0;
            cnt_d    = '0;
         end else begin
            // The sample fits the committed width; a shrink only affects later samples.
            sel_d = cur_eff;
            if (cnt_eff == LAST_CNT) begin
               cur_d    = win_upd;
               winmax_d = '0;
               cnt_d    = '0;
            end else begin
               winmax_d = win_upd;
               cnt_d    = cnt_eff + CW'(1);
            end
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= TRACK;
         cur_q    <= TOP_SEL;
         winmax_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         cur_q    <= cur_d;
         winmax_q <= winmax_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         en_q  <= 1'b0;
         sel_q <= TOP_SEL;
         d_q   <= '0;
      end else begin
         en_q  <= bus.in_valid;
         sel_q <= sel_d;
         if (bus.in_valid) d_q <= bus.in_data;
      end
   end

   assign bus.dff_en  = en_q;
   assign bus.dff_sel = sel_q;
   assign bus.dff_d   = d_q;
   assign bus.cur_sel = cur_q;

endmodule
